// File: rtl/drive_arbiter_if.sv
// Drive arbiter bus: three prioritized drive requests,
// overcurrent/fault control and the dual H-bridge outputs.
interface drive_arbiter_if;
  logic        lin_req;
  logic        man_req;
  logic        obs_req;
  logic [1:0]  lin_dir;
  logic [1:0]  man_dir;
  logic [1:0]  obs_dir;
  logic [18:0] lin_duty;
  logic [18:0] man_duty;
  logic [18:0] obs_duty;
  logic        oc_a;
  logic        oc_b;
  logic        fault_clr;
  logic        ina1;
  logic        ina2;
  logic        pwm_a;
  logic        inb1;
  logic        inb2;
  logic        pwm_b;
  logic [1:0]  grant;
  logic        fault;

  modport master (
    output lin_req, man_req, obs_req,
    output lin_dir, man_dir, obs_dir,
    output lin_duty, man_duty, obs_duty,
    output oc_a, oc_b, fault_clr,
    input  ina1, ina2, pwm_a,
    input  inb1, inb2, pwm_b,
    input  grant, fault
  );

  modport slave (
    input  lin_req, man_req, obs_req,
    input  lin_dir, man_dir, obs_dir,
    input  lin_duty, man_duty, obs_duty,
    input  oc_a, oc_b, fault_clr,
    output ina1, ina2, pwm_a,
    output inb1, inb2, pwm_b,
    output grant, fault
  );
endinterface

// File: rtl/drive_arbiter.sv
// Priority drive arbiter with PWM, direction dead time and overcurrent trip.
// Optional soft start ramp: define DRIVE_ARB_SOFTSTART_EN.
module drive_arbiter #(
  parameter int unsigned PWM_PERIOD = 250000,
  parameter int unsigned DEADTIME   = 50000,
  parameter int unsigned OC_FILTER  = 1000,
  parameter int unsigned RAMP_STEP  = 15625
) (
  input logic       clk,
  input logic       rst_n,
  drive_arbiter_if.slave bus
);

  localparam int DW = $clog2(DEADTIME + 1);
  localparam int OW = $clog2(OC_FILTER + 1);

  localparam logic [18:0]   PER   = 19'(PWM_PERIOD);
  localparam logic [18:0]   LAST  = 19'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEADTIME - 1);
  localparam logic [OW-1:0] OCMAX = OW'(OC_FILTER);
`ifdef DRIVE_ARB_SOFTSTART_EN
  localparam logic [18:0]   STEP  = 19'(RAMP_STEP);
`else
  // A full-period step reaches any clamped target at once.
  localparam logic [18:0]   STEP  = PER;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DEAD,
    FAULT
  } state_t;

  state_t        state_q;
  logic [18:0]   cnt_q;
  logic [18:0]   duty_q;
  logic [1:0]    dir_q;
  logic [1:0]    grant_q;
  logic [DW-1:0] dead_q;
  logic [OW-1:0] oca_q, oca_d;
  logic [OW-1:0] ocb_q, ocb_d;

  logic        win_any;
  logic [1:0]  win_dir;
  logic [18:0] win_duty;
  logic [1:0]  win_grant;
  logic [18:0] win_tgt;
  logic [18:0] entry_d;
  logic [18:0] wrap_d;
  logic        trip;
  logic        drv;

  function automatic logic [18:0] ramp(
    input logic [18:0] cur,
    input logic [18:0] tgt
  );
    if (tgt > cur)
      ramp = (tgt - cur > STEP) ? cur + STEP : tgt;
    else
      ramp = (cur - tgt > STEP) ? cur - STEP : tgt;
  endfunction

  always_comb begin
    win_any   = 1'b1;
    win_dir   = 2'b00;
    win_duty  = '0;
    win_grant = 2'b00;
    priority case (1'b1)
      bus.obs_req: begin
        win_dir   = bus.obs_dir;
        win_duty  = bus.obs_duty;
        win_grant = 2'b11;
      end
      bus.man_req: begin
        win_dir   = bus.man_dir;
        win_duty  = bus.man_duty;
        win_grant = 2'b10;
      end
      bus.lin_req: begin
        win_dir   = bus.lin_dir;
        win_duty  = bus.lin_duty;
        win_grant = 2'b01;
      end
      default: win_any = 1'b0;
    endcase
  end

  assign win_tgt = (win_duty >= PER) ? PER : win_duty;
  assign entry_d = ramp('0, win_tgt);
  assign wrap_d  = ramp(duty_q, win_tgt);

  always_comb begin
    oca_d = '0;
    ocb_d = '0;
    if (bus.oc_a)
      oca_d = (oca_q == OCMAX) ? oca_q : oca_q + OW'(1);
    if (bus.oc_b)
      ocb_d = (ocb_q == OCMAX) ? ocb_q : ocb_q + OW'(1);
  end

  assign trip = (oca_q == OCMAX) || (ocb_q == OCMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oca_q <= '0;
      ocb_q <= '0;
    end else begin
      oca_q <= oca_d;
      ocb_q <= ocb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      dir_q   <= 2'b11;
      grant_q <= 2'b00;
      dead_q  <= '0;
    end else if (trip) begin
      state_q <= FAULT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_any) begin
            state_q <= DRIVE;
            cnt_q   <= '0;
            duty_q  <= entry_d;
            dir_q   <= win_dir;
            grant_q <= win_grant;
          end
        end
        DRIVE: begin
          if (!win_any) begin
            state_q <= IDLE;
          end else if (win_dir != dir_q) begin
            state_q <= DEAD;
            dead_q  <= '0;
          end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            duty_q  <= wrap_d;
            grant_q <= win_grant;
          end else begin
            cnt_q <= cnt_q + 19'd1;
          end
        end
        DEAD: begin
          // Only the winner present at expiry is applied.
          if (dead_q != DLAST) begin
            dead_q <= dead_q + DW'(1);
          end else if (win_any) begin
            state_q <= DRIVE;
            cnt_q   <= '0;
            duty_q  <= entry_d;
            dir_q   <= win_dir;
            grant_q <= win_grant;
          end else begin
            state_q <= IDLE;
          end
        end
        FAULT: begin
          if (bus.fault_clr && !bus.oc_a && !bus.oc_b)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoded from registers so async reset clears the bridge at once.
  assign drv       = (state_q == DRIVE);
  assign bus.pwm_a = drv && (cnt_q < duty_q);
  assign bus.pwm_b = drv && (cnt_q < duty_q);
  assign bus.ina1  = drv && !dir_q[0];
  assign bus.ina2  = drv && dir_q[0];
  assign bus.inb1  = drv && dir_q[1];
  assign bus.inb2  = drv && !dir_q[1];
  assign bus.grant = drv ? grant_q : 2'b00;
  assign bus.fault = (state_q == FAULT);

endmodule

// File: tb/tb_drive_arbiter.sv
// Scoreboarded bench for drive_arbiter at reduced period and filter sizes.
// Expected per-period high counts are queued before each measurement.
module tb_drive_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   exp_q[$];
  int   cur;
  int   ha, hb, a1, b1, a2, b2;

  drive_arbiter_if bus ();

  drive_arbiter #(
    .PWM_PERIOD(100),
    .DEADTIME  (20),
    .OC_FILTER (8),
    .RAMP_STEP (25)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input int got);
    int e;
    if (exp_q.size() == 0) e = -1;
    else e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure(input int n, output int ca, output int cb);
    ca = 0;
    cb = 0;
    repeat (n) begin
      ca += int'(bus.pwm_a);
      cb += int'(bus.pwm_b);
      step(1);
    end
  endtask

  function automatic int pins();
    return int'({bus.ina1, bus.ina2, bus.inb1, bus.inb2});
  endfunction

  // Duty in force for a period: target clamped to 100, ramped by 25 if soft start.
  function automatic int applied(input int prev, input int tgt, input bit entry);
    int t;
    int b;
    t = (tgt > 100) ? 100 : tgt;
    b = entry ? 0 : prev;
`ifdef DRIVE_ARB_SOFTSTART_EN
    if (t > b) return (t - b > 25) ? b + 25 : t;
    return (b - t > 25) ? b - 25 : t;
`else
    return (b >= 0) ? t : t;
`endif
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.lin_req = 0; bus.man_req = 0; bus.obs_req = 0;
    bus.lin_dir = 0; bus.man_dir = 0; bus.obs_dir = 0;
    bus.lin_duty = 0; bus.man_duty = 0; bus.obs_duty = 0;
    bus.oc_a = 0; bus.oc_b = 0; bus.fault_clr = 0;
    #3;
    check("rst_outs", int'({bus.pwm_a, bus.pwm_b, bus.grant, bus.fault}), 0);
    check("rst_pins", pins(), 0);
    step(3);
    rst_n = 1'b1;
    step(2);
    check("idle_grant", int'(bus.grant), 0);

    // line follower alone
    bus.lin_req = 1; bus.lin_dir = 2'b11; bus.lin_duty = 19'd30;
    cur = applied(0, 30, 1);
    step(1);
    check("lin_grant", int'(bus.grant), 1);
    push(cur); push(cur);
    measure(100, ha, hb);
    pop_chk("lin_a", ha);
    pop_chk("lin_b", hb);

    // manual outranks line; new duty waits for the wrap
    bus.man_req = 1; bus.man_dir = 2'b11; bus.man_duty = 19'd40;
    push(cur);
    measure(100, ha, hb);
    pop_chk("lin_hold", ha);
    cur = applied(cur, 40, 0);
    check("man_grant", int'(bus.grant), 2);
    check("man_pins", pins(), 4'b0110);
    push(cur); push(cur);
    measure(100, ha, hb);
    pop_chk("man_a", ha);
    pop_chk("man_b", hb);

    // duty change mid-period
    push(cur);
    measure(10, a1, b1);
    bus.man_duty = 19'd80;
    measure(90, a2, b2);
    pop_chk("mid_keep", a1 + a2);
    cur = applied(cur, 80, 0);
    push(cur);
    measure(100, ha, hb);
    pop_chk("mid_next", ha);

    // duty 0 gives constant low once applied
    bus.man_duty = 19'd0;
    push(cur);
    measure(100, ha, hb);
    pop_chk("z_hold", ha);
    cur = applied(cur, 0, 0);
    push(cur);
    measure(100, ha, hb);
    pop_chk("z_duty", ha);

    // obstacle with reversed dir forces dead time
    bus.obs_req = 1; bus.obs_dir = 2'b00; bus.obs_duty = 19'd100;
    step(1);
    push(0);
    ha = 0;
    repeat (20) begin
      ha += int'(bus.pwm_a | bus.pwm_b) + pins();
      step(1);
    end
    pop_chk("dead_low", ha);
    cur = applied(0, 100, 1);
    check("obs_grant", int'(bus.grant), 3);
    check("obs_pins", pins(), 4'b1001);
    push(cur); push(cur);
    measure(100, ha, hb);
    pop_chk("obs_a", ha);
    pop_chk("obs_b", hb);

    // overcurrent filter and latch
    bus.oc_b = 1;
    step(7);
    bus.oc_b = 0;
    step(3);
    check("oc7_nofault", int'(bus.fault), 0);
    bus.oc_b = 1;
    step(8);
    check("oc8_edge", int'(bus.fault), 0);
    step(1);
    check("oc_fault", int'(bus.fault), 1);
    check("oc_outs", int'({bus.pwm_a, bus.pwm_b, bus.grant}) + pins(), 0);
    bus.fault_clr = 1;
    step(1);
    bus.fault_clr = 0;
    step(1);
    check("clr_ignored", int'(bus.fault), 1);
    bus.oc_b = 0;
    step(2);
    bus.fault_clr = 1;
    step(1);
    bus.fault_clr = 0;
    check("clr_fault", int'(bus.fault), 0);
    check("clr_idle", int'(bus.grant), 0);
    step(1);
    check("clr_drive", int'(bus.grant), 3);

    // async reset while pwm high
    step(20);
    check("pre_rst", int'(bus.pwm_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", int'({bus.pwm_a, bus.pwm_b}), 0);
    bus.obs_req = 0; bus.man_req = 0; bus.lin_req = 0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check("post_rst", int'({bus.grant, bus.fault}) + pins(), 0);

    // full duty from idle, ramped if soft start is built in
    bus.man_req = 1; bus.man_dir = 2'b11; bus.man_duty = 19'd100;
    step(1);
    cur = applied(0, 100, 1);
    for (int p = 0; p < 4; p++) begin
      push(cur);
      measure(100, ha, hb);
      pop_chk($sformatf("ramp%0d", p), ha);
      cur = applied(cur, 100, 0);
    end

    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/drive_arbiter.md
DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 Parameters SHALL be: PWM_PERIOD 250000 (clk cycles per carrier period, 400 Hz at 100 MHz); DEADTIME 50000 (brake cycles on direction change); OC_FILTER 1000 (consecutive overcurrent cycles to trip); RAMP_STEP 15625 (duty increment per period, softstart only).
REQ-002 clk  in  1  system clock, 100 MHz.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 lin_req, man_req, obs_req  in  1 each  drive requests: line follower, manual switches, obstacle avoider.
REQ-005 lin_dir, man_dir, obs_dir  in  2 each  bit0 = motor A forward, bit1 = motor B forward.
REQ-006 lin_duty, man_duty, obs_duty  in  19 each  requested high-cycles per period, both motors.
REQ-007 oc_a, oc_b  in  1 each  overcurrent flags, motor A / B, active-high, synchronous to clk.
REQ-008 fault_clr  in  1  single-cycle fault-release pulse.
REQ-009 ina1, ina2, pwm_a  out  1 each  motor A bridge direction pair and enable.
REQ-010 inb1, inb2, pwm_b  out  1 each  motor B bridge direction pair and enable.
REQ-011 grant  out  2  00 none, 01 line, 10 manual, 11 obstacle.
REQ-012 fault  out  1  overcurrent latch.

Function
REQ-013 Winner SHALL be chosen each cycle by fixed priority obs > man > lin; grant shows the source whose dir/duty is applied.
REQ-014 PWM counter SHALL count 0..PWM_PERIOD-1 and wrap; pwm_x = 1 while counter < applied duty and state = DRIVE.
REQ-015 Duty >= PWM_PERIOD SHALL be clamped to 100%; duty 0 SHALL give constant low.
REQ-016 Direction map: motor A fwd ina1/ina2 = 0/1, rev = 1/0; motor B fwd inb1/inb2 = 1/0, rev = 0/1; brake and coast = 0/0.
REQ-017 States SHALL be IDLE, DRIVE, DEAD, FAULT.
REQ-018 IDLE: pwm 0, in pins 0/0, grant 00; any request -> DRIVE, latching the winner's dir/duty, counter restarted at 0.
REQ-019 DRIVE: a new winner duty with the same dir SHALL take effect at the next counter wrap, never mid-period.
REQ-020 DRIVE: a winner dir differing from applied dir in either bit SHALL go to DEAD the next cycle with pwm 0 and in pins 0/0.
REQ-021 DRIVE: no request -> IDLE the next cycle.
REQ-022 DEAD: hold brake for DEADTIME cycles, then latch the current winner and go to DRIVE, or to IDLE if no request.
REQ-023 Overcurrent: a per-motor counter increments while oc_x = 1, clears when oc_x = 0; reaching OC_FILTER SHALL force FAULT from any state the next cycle.
REQ-024 FAULT: fault = 1, pwm 0, in pins 0/0, grant 00; exit to IDLE only on fault_clr = 1 while oc_a = oc_b = 0; fault_clr otherwise ignored.
REQ-025 Trip and fault_clr in the same cycle: trip SHALL win.
REQ-026 Requests changing during DEAD SHALL NOT restart the dead timer; only the winner at expiry is applied.

Reset
REQ-027 While rst_n = 0: state IDLE, counters 0, applied duty 0, applied dir 2'b11, all outputs 0, fault 0.
REQ-028 Reset assertion mid-period or mid-DEAD SHALL drive pwm_a/pwm_b low immediately, without waiting for clk.

Configuration
REQ-029 With DRIVE_ARB_SOFTSTART_EN defined, applied duty SHALL step toward target by at most RAMP_STEP per counter wrap, entry to DRIVE starting from 0; without it, target applies in full at the next wrap (entry from IDLE/DEAD immediate).

Verification (PWM_PERIOD 100, DEADTIME 20, OC_FILTER 8, RAMP_STEP 25)
REQ-030 man_req=1, dir 11, duty 40 -> grant 10, pwm_a/pwm_b high 40 of every 100 cycles, ina1/ina2 = 0/1, inb1/inb2 = 1/0.
REQ-031 man driving, obs_req=1 dir 00 duty 100 -> grant 11, pins 0/0 and pwm low 20 cycles, then pwm constant high, ina1/ina2 = 1/0.
REQ-032 man duty 40 -> 80 at counter 10 -> current period keeps 40 high cycles; next period 80.
REQ-033 oc_b high 7 cycles then low, then high 8 cycles -> no trip, then fault = 1, outputs low; fault_clr with oc_b = 1 ignored; with oc_b = 0 -> IDLE.
REQ-034 rst_n low at counter 20 while pwm high -> pwm low same cycle; after release state IDLE, grant 00.
REQ-035 Softstart build, man duty 100 from IDLE -> high times 25, 50, 75, 100 over four periods.
